// File: rtl/muldiv_seq_if.sv
// Operation bus for the sequential multiply/divide unit.
// The requester side drives the command and operands; the unit returns status and results.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       ALUctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, ALUctrl, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, ALUctrl, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiplier (radix-2 shift-add) and restoring divider.
// One bit per cycle for WIDTH cycles, then a one-cycle done pulse that loads hi/lo.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_seq_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [5:0] OP_MUL = 6'h13;
    localparam logic [5:0] OP_DIV = 6'h34;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Multiply step: acc = {partial product, remaining multiplier bits}; the
    // WIDTH+1-bit sum keeps the carry so nothing is truncated on the shift.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_next;

    assign mul_sum      = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q})
                                   :  {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign mul_acc_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step on a WIDTH+1-bit partial remainder; the result of a
    // successful subtract always fits back into WIDTH bits.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;

    assign div_shift    = {rem_q, quo_q[WIDTH-1]};
    assign div_ge       = (div_shift >= {1'b0, b_q});
    assign div_rem_next = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
    assign div_quo_next = {quo_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && (bus.ALUctrl == OP_MUL)) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = {{WIDTH{1'b0}}, bus.b};
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = MUL;
                end else if (bus.start && (bus.ALUctrl == OP_DIV)) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    rem_d   = '0;
                    quo_d   = bus.a;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = DIV;
                end
            end
            MUL: begin
                acc_d = mul_acc_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    hi_d    = mul_acc_next[2*WIDTH-1:WIDTH];
                    lo_d    = mul_acc_next[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DIV: begin
                rem_d = div_rem_next;
                quo_d = div_quo_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    hi_d    = div_rem_next;
                    lo_d    = div_quo_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == MUL) || (state_q == DIV);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
